// File: rtl/sram_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_ctrl
// Purpose  : Two-port arbitrated controller for an external asynchronous
//            SRAM. Port 0 serves the SoC bus and port 1 a DMA/video master.
//            Each access is IDLE -> ACCESS (WAIT_CYCLES+1) -> RECOVER, with
//            byte-lane writes and registered pad outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int PRIO_MODE   = 0
) (
    input  logic                  CLK0,
    input  logic                  reset_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DATA_W/8-1:0]   p0_be,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_ack,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DATA_W/8-1:0]   p1_be,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_ack,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_in,
    output logic                  sram_cs_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                last_grant, last_grant_nxt;
    logic                gnt, gnt_nxt;
    logic                we_lat, we_lat_nxt;

    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   dq_out_nxt;
    logic                dq_oe_nxt;
    logic                cs_n_nxt, oe_n_nxt, we_n_nxt, ub_n_nxt, lb_n_nxt;
    logic                p0_ack_nxt, p1_ack_nxt;
    logic [DATA_W-1:0]   p0_rdata_nxt, p1_rdata_nxt;

    logic                any_req;
    logic                pick;
    logic                sel_we;
    logic [1:0]          sel_be;

    // Arbitration: a lone requester wins; a tie goes to port 0 or alternates
    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            pick = (PRIO_MODE == 1) ? 1'b0 : ~last_grant;
        end else begin
            pick = p1_req;
        end
        sel_we = pick ? p1_we : p0_we;
        sel_be = pick ? 2'(p1_be) : 2'(p0_be);
    end

    // Next-state and next-output logic; pad values are registered on entry
    // to each state so every output comes straight from a flop
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        gnt_nxt        = gnt;
        we_lat_nxt     = we_lat;
        addr_nxt       = sram_addr;
        dq_out_nxt     = sram_dq_out;
        dq_oe_nxt      = sram_dq_oe;
        cs_n_nxt       = sram_cs_n;
        oe_n_nxt       = sram_oe_n;
        we_n_nxt       = sram_we_n;
        ub_n_nxt       = sram_ub_n;
        lb_n_nxt       = sram_lb_n;
        p0_ack_nxt     = 1'b0;
        p1_ack_nxt     = 1'b0;
        p0_rdata_nxt   = p0_rdata;
        p1_rdata_nxt   = p1_rdata;

        case (state)
            IDLE: begin
                cs_n_nxt  = 1'b1;
                oe_n_nxt  = 1'b1;
                we_n_nxt  = 1'b1;
                ub_n_nxt  = 1'b1;
                lb_n_nxt  = 1'b1;
                dq_oe_nxt = 1'b0;
                if (any_req) begin
                    state_nxt      = ACCESS;
                    cnt_nxt        = 4'd0;
                    gnt_nxt        = pick;
                    last_grant_nxt = pick;
                    we_lat_nxt     = sel_we;
                    addr_nxt       = pick ? p1_addr : p0_addr;
                    cs_n_nxt       = 1'b0;
                    if (sel_we) begin
                        we_n_nxt   = 1'b0;
                        dq_oe_nxt  = 1'b1;
                        dq_out_nxt = pick ? p1_wdata : p0_wdata;
                        lb_n_nxt   = ~sel_be[0];
                        ub_n_nxt   = ~sel_be[1];
                    end else begin
                        oe_n_nxt   = 1'b0;
                        lb_n_nxt   = 1'b0;
                        ub_n_nxt   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (cnt == LAST_CNT) begin
                    state_nxt  = RECOVER;
                    we_n_nxt   = 1'b1;
                    oe_n_nxt   = 1'b1;
                    ub_n_nxt   = 1'b1;
                    lb_n_nxt   = 1'b1;
                    p0_ack_nxt = ~gnt;
                    p1_ack_nxt = gnt;
                    // Writes keep cs_n, address and data through RECOVER for
                    // hold time; reads release the chip and capture the bus
                    if (!we_lat) begin
                        cs_n_nxt = 1'b1;
                        if (gnt) begin
                            p1_rdata_nxt = sram_dq_in;
                        end else begin
                            p0_rdata_nxt = sram_dq_in;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RECOVER: begin
                state_nxt = IDLE;
                cs_n_nxt  = 1'b1;
                oe_n_nxt  = 1'b1;
                we_n_nxt  = 1'b1;
                ub_n_nxt  = 1'b1;
                lb_n_nxt  = 1'b1;
                dq_oe_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // An 8-bit part has no upper lane
        if (DATA_W == 8) begin
            ub_n_nxt = 1'b1;
        end
    end

    // State, bookkeeping and pad registers with synchronous active-low reset
    always_ff @(posedge CLK0) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_grant  <= 1'b1;
            gnt         <= 1'b0;
            we_lat      <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_cs_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_grant  <= last_grant_nxt;
            gnt         <= gnt_nxt;
            we_lat      <= we_lat_nxt;
            sram_addr   <= addr_nxt;
            sram_dq_out <= dq_out_nxt;
            sram_dq_oe  <= dq_oe_nxt;
            sram_cs_n   <= cs_n_nxt;
            sram_oe_n   <= oe_n_nxt;
            sram_we_n   <= we_n_nxt;
            sram_ub_n   <= ub_n_nxt;
            sram_lb_n   <= lb_n_nxt;
            p0_ack      <= p0_ack_nxt;
            p1_ack      <= p1_ack_nxt;
            p0_rdata    <= p0_rdata_nxt;
            p1_rdata    <= p1_rdata_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arb_ctrl
// Purpose  : Directed self-checking bench for sram_arb_ctrl. Three instances:
//            d0 = W1 round-robin, d1 = W3 fixed priority, d2 = W0 round-robin,
//            each with its own behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arb_ctrl;

    logic        CLK0 = 1'b0;
    logic        reset_n;
    logic        p0_req [3];
    logic        p1_req [3];
    logic        p0_we, p1_we;
    logic [1:0]  p0_be, p1_be;
    logic [17:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;

    logic [15:0] p0_rdata [3];
    logic [15:0] p1_rdata [3];
    logic        p0_ack [3];
    logic        p1_ack [3];
    logic [17:0] sram_addr [3];
    logic [15:0] dq_out [3];
    logic [15:0] dq_in [3];
    logic        dq_oe [3];
    logic        cs_n [3];
    logic        oe_n [3];
    logic        we_n [3];
    logic        ub_n [3];
    logic        lb_n [3];

    logic [15:0] mem [3][256];
    logic        mem_init;

    int vectors    = 0;
    int miscompares = 0;
    int proto_err  = 0;

    always #5 CLK0 = ~CLK0;

    function automatic logic [15:0] init_val(input int a);
        logic [7:0] b;
        b = 8'(a);
        if (a == 16'h23) return 16'hBEEF;
        if (a == 16'h10) return 16'h1234;
        return {~b, b};
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_dut
        sram_arb_ctrl #(
            .ADDR_W      (18),
            .DATA_W      (16),
            .WAIT_CYCLES ((i == 0) ? 1 : (i == 1) ? 3 : 0),
            .PRIO_MODE   ((i == 1) ? 1 : 0)
        ) dut (
            .CLK0        (CLK0),
            .reset_n     (reset_n),
            .p0_req      (p0_req[i]),
            .p0_we       (p0_we),
            .p0_be       (p0_be),
            .p0_addr     (p0_addr),
            .p0_wdata    (p0_wdata),
            .p0_rdata    (p0_rdata[i]),
            .p0_ack      (p0_ack[i]),
            .p1_req      (p1_req[i]),
            .p1_we       (p1_we),
            .p1_be       (p1_be),
            .p1_addr     (p1_addr),
            .p1_wdata    (p1_wdata),
            .p1_rdata    (p1_rdata[i]),
            .p1_ack      (p1_ack[i]),
            .sram_addr   (sram_addr[i]),
            .sram_dq_out (dq_out[i]),
            .sram_dq_oe  (dq_oe[i]),
            .sram_dq_in  (dq_in[i]),
            .sram_cs_n   (cs_n[i]),
            .sram_oe_n   (oe_n[i]),
            .sram_we_n   (we_n[i]),
            .sram_ub_n   (ub_n[i]),
            .sram_lb_n   (lb_n[i])
        );

        // SRAM drives the bus only while selected and output-enabled
        assign dq_in[i] = (!cs_n[i] && !oe_n[i]) ? mem[i][sram_addr[i][7:0]] : 16'h0000;
    end

    // Behavioural SRAM: preload on request, otherwise byte-lane writes
    always @(posedge CLK0) begin
        if (mem_init) begin
            for (int d = 0; d < 3; d++)
                for (int a = 0; a < 256; a++)
                    mem[d][a] <= init_val(a);
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (!cs_n[d] && !we_n[d]) begin
                    if (!lb_n[d]) mem[d][sram_addr[d][7:0]][7:0]  <= dq_out[d][7:0];
                    if (!ub_n[d]) mem[d][sram_addr[d][7:0]][15:8] <= dq_out[d][15:8];
                end
            end
        end
    end

    // Pad-protocol watch: strobes never overlap, no bus fight
    always @(negedge CLK0) begin
        if (reset_n) begin
            for (int d = 0; d < 3; d++) begin
                if (!we_n[d] && !oe_n[d]) proto_err <= proto_err + 1;
                else if (dq_oe[d] && !oe_n[d]) proto_err <= proto_err + 1;
            end
        end
    end

    task automatic tick();
        @(posedge CLK0);
        #1;
    endtask

    task automatic test_reset();
        mem_init = 1'b1;
        reset_n  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            p0_req[d] = 1'b0;
            p1_req[d] = 1'b0;
        end
        p0_we = 0; p1_we = 0; p0_be = 0; p1_be = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        tick();
        mem_init = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if ({cs_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d], dq_oe[d], p0_ack[d], p1_ack[d]} !== 8'b11111000)
                begin miscompares++; $display("FAIL reset_strobes d%0d: got %b want 11111000", d,
                    {cs_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d], dq_oe[d], p0_ack[d], p1_ack[d]}); end
            vectors++;
            if ({sram_addr[d], dq_out[d], p0_rdata[d], p1_rdata[d]} !== '0)
                begin miscompares++; $display("FAIL reset_values d%0d: addr %h dq %h r0 %h r1 %h want all 0",
                    d, sram_addr[d], dq_out[d], p0_rdata[d], p1_rdata[d]); end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        p0_addr = 18'h00123; p0_we = 1'b0; p0_req[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++;
            if (c <= 2) begin
                if ({cs_n[0], oe_n[0], we_n[0], dq_oe[0], p0_ack[0], ub_n[0], lb_n[0]} !== 7'b0010000 ||
                    sram_addr[0] !== 18'h00123)
                    begin miscompares++; $display("FAIL read_access c%0d: pads %b addr %h want 0010000 00123", c,
                        {cs_n[0], oe_n[0], we_n[0], dq_oe[0], p0_ack[0], ub_n[0], lb_n[0]}, sram_addr[0]); end
            end else begin
                if (p0_ack[0] !== 1'b1 || p1_ack[0] !== 1'b0 || oe_n[0] !== 1'b1 || p0_rdata[0] !== 16'hBEEF)
                    begin miscompares++; $display("FAIL read_ack: ack %b/%b oe_n %b rdata %h want 1/0 1 BEEF",
                        p0_ack[0], p1_ack[0], oe_n[0], p0_rdata[0]); end
            end
        end
        p0_req[0] = 1'b0;
        tick();
        vectors++;
        if (p0_ack[0] !== 1'b0 || p0_rdata[0] !== 16'hBEEF || cs_n[0] !== 1'b1)
            begin miscompares++; $display("FAIL read_after: ack %b rdata %h cs_n %b want 0 BEEF 1",
                p0_ack[0], p0_rdata[0], cs_n[0]); end
    endtask

    task automatic test_write();
        p0_addr = 18'h00010; p0_we = 1'b1; p0_be = 2'b01; p0_wdata = 16'hA55A; p0_req[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++;
            if (c <= 2) begin
                if ({cs_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], dq_oe[0], p0_ack[0]} !== 7'b0100110 ||
                    dq_out[0] !== 16'hA55A || sram_addr[0] !== 18'h00010)
                    begin miscompares++; $display("FAIL write_access c%0d: pads %b dq %h addr %h want 0100110 A55A 00010",
                        c, {cs_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], dq_oe[0], p0_ack[0]}, dq_out[0], sram_addr[0]); end
            end else begin
                if ({p0_ack[0], we_n[0], oe_n[0], cs_n[0], dq_oe[0]} !== 5'b11101 || dq_out[0] !== 16'hA55A)
                    begin miscompares++; $display("FAIL write_recover: ack/we_n/oe_n/cs_n/oe %b dq %h want 11101 A55A",
                        {p0_ack[0], we_n[0], oe_n[0], cs_n[0], dq_oe[0]}, dq_out[0]); end
            end
        end
        p0_req[0] = 1'b0;
        tick();
        vectors++;
        if (cs_n[0] !== 1'b1 || dq_oe[0] !== 1'b0 || mem[0][16] !== 16'h125A)
            begin miscompares++; $display("FAIL write_result: cs_n %b dq_oe %b mem %h want 1 0 125A",
                cs_n[0], dq_oe[0], mem[0][16]); end
        p0_we = 1'b0; p0_req[0] = 1'b1;
        repeat (3) tick();
        vectors++;
        if (p0_ack[0] !== 1'b1 || p0_rdata[0] !== 16'h125A)
            begin miscompares++; $display("FAIL write_readback: ack %b rdata %h want 1 125A", p0_ack[0], p0_rdata[0]); end
        p0_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int n;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        p0_addr = 18'h00040; p1_addr = 18'h00041; p0_we = 1'b0; p1_we = 1'b0;
        p0_req[0] = 1'b1; p1_req[0] = 1'b1;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (p0_ack[0] || p1_ack[0]) begin
                vectors++;
                if (n >= 4 || c != 3 + 4 * n ||
                    {p0_ack[0], p1_ack[0]} !== ((n % 2 == 0) ? 2'b10 : 2'b01) ||
                    (p0_ack[0] && p0_rdata[0] !== 16'hBF40) || (p1_ack[0] && p1_rdata[0] !== 16'hBE41))
                    begin miscompares++; $display("FAIL rr_grant #%0d: cycle %0d acks %b r0 %h r1 %h want cycle %0d acks %b BF40/BE41",
                        n, c, {p0_ack[0], p1_ack[0]}, p0_rdata[0], p1_rdata[0], 3 + 4 * n,
                        (n % 2 == 0) ? 2'b10 : 2'b01); end
                n++;
                if (n == 4) begin p0_req[0] = 1'b0; p1_req[0] = 1'b0; end
            end
        end
        p0_req[0] = 1'b0; p1_req[0] = 1'b0;
        vectors++;
        if (n != 4) begin miscompares++; $display("FAIL rr_count: got %0d acks want 4", n); end
    endtask

    task automatic test_priority();
        int n;
        p0_addr = 18'h00050; p1_addr = 18'h00051; p0_we = 1'b0; p1_we = 1'b0;
        p0_req[1] = 1'b1; p1_req[1] = 1'b1;
        n = 0;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (p0_ack[1] || p1_ack[1]) begin
                vectors++;
                if (n >= 5 || c != ((n < 4) ? 5 + 6 * n : 29) ||
                    {p0_ack[1], p1_ack[1]} !== ((n < 4) ? 2'b10 : 2'b01) ||
                    (p0_ack[1] && p0_rdata[1] !== 16'hAF50) || (p1_ack[1] && p1_rdata[1] !== 16'hAE51))
                    begin miscompares++; $display("FAIL prio_grant #%0d: cycle %0d acks %b r0 %h r1 %h want cycle %0d acks %b AF50/AE51",
                        n, c, {p0_ack[1], p1_ack[1]}, p0_rdata[1], p1_rdata[1], (n < 4) ? 5 + 6 * n : 29,
                        (n < 4) ? 2'b10 : 2'b01); end
                n++;
                if (n == 4) p0_req[1] = 1'b0;
                if (n == 5) p1_req[1] = 1'b0;
            end
        end
        p0_req[1] = 1'b0; p1_req[1] = 1'b0;
        vectors++;
        if (n != 5) begin miscompares++; $display("FAIL prio_count: got %0d acks want 5", n); end
    endtask

    task automatic test_wait0();
        p0_addr = 18'h00060; p0_we = 1'b0; p0_req[2] = 1'b1;
        tick();
        vectors++;
        if (oe_n[2] !== 1'b0 || cs_n[2] !== 1'b0 || p0_ack[2] !== 1'b0)
            begin miscompares++; $display("FAIL w0_access: oe_n %b cs_n %b ack %b want 0 0 0", oe_n[2], cs_n[2], p0_ack[2]); end
        tick();
        vectors++;
        if (p0_ack[2] !== 1'b1 || p0_rdata[2] !== 16'h9F60)
            begin miscompares++; $display("FAIL w0_ack: ack %b rdata %h want 1 9F60", p0_ack[2], p0_rdata[2]); end
        p0_req[2] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int acks;
        p0_addr = 18'h00012; p0_we = 1'b1; p0_be = 2'b11; p0_wdata = 16'h1111; p0_req[0] = 1'b1;
        tick();
        vectors++;
        if (we_n[0] !== 1'b0 || cs_n[0] !== 1'b0)
            begin miscompares++; $display("FAIL abort_start: we_n %b cs_n %b want 0 0", we_n[0], cs_n[0]); end
        reset_n = 1'b0;
        tick();
        vectors++;
        if ({cs_n[0], we_n[0], dq_oe[0], p0_ack[0]} !== 4'b1100)
            begin miscompares++; $display("FAIL abort_reset: cs_n/we_n/dq_oe/ack %b want 1100",
                {cs_n[0], we_n[0], dq_oe[0], p0_ack[0]}); end
        reset_n = 1'b1;
        p0_req[0] = 1'b0;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (p0_ack[0] || p1_ack[0]) acks++;
        end
        vectors++;
        if (acks != 0) begin miscompares++; $display("FAIL abort_noack: got %0d acks want 0", acks); end
        p0_addr = 18'h00070; p0_we = 1'b0; p0_req[0] = 1'b1;
        repeat (3) tick();
        vectors++;
        if (p0_ack[0] !== 1'b1 || p0_rdata[0] !== 16'h8F70)
            begin miscompares++; $display("FAIL abort_fresh_read: ack %b rdata %h want 1 8F70", p0_ack[0], p0_rdata[0]); end
        p0_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_protocol();
        vectors++;
        if (proto_err !== 0)
            begin miscompares++; $display("FAIL pad_protocol: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_priority();
        test_wait0();
        test_reset_mid();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
